mfp_ahb_disp_writer: RTL and testbench
======================================

Name: mfp_ahb_disp_writer

Overview:
- AHB-Lite master (initiator) that pushes a complete seven-segment display image (enable, digits low, digits high, decimal points) to the display slave as four pipelined single-word writes.
- Lets hardware (self-test, boot splash, debug monitor) drive the display without MIPSfpga processor involvement.
- Sits on the display slave's port of the AHB-Lite interconnect, in front of its mux.

Parameters:
- EN_ADDR, 32'h1F70_0000, display enable register address
- DIGL_ADDR, 32'h1F70_0004, digits[31:0] register address
- DIGH_ADDR, 32'h1F70_0008, digits[63:32] register address
- DP_ADDR, 32'h1F70_000C, decimal-point register address
- REFRESH_CYCLES, 50_000_000, auto-refresh period in HCLK cycles (used only with the optional feature)

Ports:
- HCLK  in  1  bus clock; sole clock
- HRESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send an image; ignored while busy=1
- en_val  in  8  enable byte, active low per digit
- digits_val  in  64  digit codes, 8 bits per digit
- dp_val  in  8  decimal-point byte, active low
- HADDR  out  32  address phase
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE  out  1  held at 1 during NONSEQ, 0 otherwise
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWDATA  out  32  data phase
- HREADY  in  1  transfer-complete / wait-state input
- HRESP  in  1  0=OKAY, 1=ERROR
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky; set on ERROR response, cleared by the next accepted start

Behaviour:
- Reset values:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0
  - busy=0, done=0, err=0
  - snapshot registers: en=8'hFF, digits=all 1s, dp=8'hFF (blank display)
- States: IDLE, ADDR, PIPE, LAST, ERR1.
- IDLE:
  - On start=1, latch en_val, digits_val and dp_val into the snapshot, set busy, clear err, and go to ADDR.
- Transfer order is fixed: index 0..3 = EN, DIGL, DIGH, DP.
  - HWDATA for EN = {24'h0, en}; for DIGL = digits[31:0]; for DIGH = digits[63:32]; for DP = {24'h0, dp}.
- ADDR (cycle after start):
  - Drive HTRANS=NONSEQ, HADDR=addr[0], HWRITE=1, then go to PIPE with idx=1.
- PIPE:
  - HWDATA carries data[idx-1] (data phase); HADDR/HTRANS carry addr[idx] (address phase).
  - Advance only when HREADY=1.
  - When HREADY=0, hold HADDR, HTRANS, HWRITE and HWDATA stable.
  - After the address phase of idx 3 is accepted, go to LAST.
- LAST:
  - HTRANS=IDLE; HWDATA=data[3] held until HREADY=1.
  - Then pulse done for 1 cycle, clear busy, and return to IDLE.
- Zero-wait-state timing (start sampled at cycle 0):
  - Addresses in cycles 1-4.
  - Data in cycles 2-5.
  - done=1 and busy=0 in cycle 6.
  - Next start is accepted in cycle 6.
- Error handling:
  - In any data phase, HRESP=1 with HREADY=0 (first error cycle): drive HTRANS=IDLE immediately, cancelling the pending address, and go to ERR1.
  - ERR1: wait for HRESP=1 with HREADY=1, then set err, clear busy, go to IDLE. No done pulse, no retry.
- start asserted while busy=1 is dropped, not queued.
- start and HRESET asserted in the same cycle: reset wins.
- HRESET mid-sequence:
  - Outputs return to reset values next cycle; HTRANS=IDLE immediately.
  - Any partially written image is left as is at the slave.

Optional Feature:
- Macro: MFP_DISP_WRITER_AUTO_REFRESH_EN.
- Defined:
  - A free-running counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap while in IDLE, the block starts a sequence re-sending the current snapshot; inputs are not re-latched.
  - Wrap while busy is dropped.
  - An external start in the same cycle as a wrap takes priority and latches the new inputs.
  - The counter resets to 0 on HRESET and on every accepted start.
- Not defined: no counter is built; sequences start only from start.

Decomposition:
- Shared package / include (mfp_ahb_const) holds:
  - HTRANS encodings (HTRANS_IDLE, HTRANS_NONSEQ)
  - HSIZE_WORD, HBURST_SINGLE
  - the four display register address constants, which are the parameter defaults
  - state encodings
- One natural sub-module: mfp_disp_refresh_timer (period counter plus wrap pulse), instantiated only when the macro is defined.

Test Plan:
1. Zero-wait write: en_val=8'hF0, digits_val=64'h0102030405060708, dp_val=8'hFE, start at cycle 0 ->
   - HADDR = EN, DIGL, DIGH, DP in cycles 1-4
   - HWDATA = 32'h000000F0, 32'h05060708, 32'h01020304, 32'h000000FE in cycles 2-5
   - done pulse in cycle 6
2. Wait states: HREADY=0 for 2 cycles during the DIGL data phase ->
   - HADDR=DIGH_ADDR and HWDATA=32'h05060708 held stable through the stall
   - done in cycle 8
3. Error: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on the DIGH data phase ->
   - HTRANS=IDLE in the first error cycle
   - DP address never issued; err=1, busy=0, no done
   - a subsequent start clears err
4. start pulsed in cycle 3 of an active sequence -> ignored; exactly 4 transfers and one done.
5. HRESET asserted in cycle 3 -> next cycle HTRANS=IDLE, busy=0, snapshot back to all-1s; no done.
6. With MFP_DISP_WRITER_AUTO_REFRESH_EN and REFRESH_CYCLES=20, after one start ->
   - the same 4-write sequence repeats every 20 cycles with identical HWDATA
   - a start coinciding with a wrap latches the new values

Source files
------------

// File: rtl/mfp_ahb_disp_writer_pkg.sv
// Shared constants for the display writer: AHB-Lite encodings, display
// register map, FSM state encoding and the display image payload.
package mfp_ahb_disp_writer_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DIGITS_W = 64;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [ADDR_W-1:0] DISP_EN_ADDR   = 32'h1F70_0000;
  localparam logic [ADDR_W-1:0] DISP_DIGL_ADDR = 32'h1F70_0004;
  localparam logic [ADDR_W-1:0] DISP_DIGH_ADDR = 32'h1F70_0008;
  localparam logic [ADDR_W-1:0] DISP_DP_ADDR   = 32'h1F70_000C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PIPE,
    S_LAST,
    S_ERR1
  } disp_state_e;

  typedef struct packed {
    logic [7:0]          en;
    logic [DIGITS_W-1:0] digits;
    logic [7:0]          dp;
  } disp_image_t;

  // All ones blanks every digit (enable and dp are active low).
  localparam disp_image_t IMAGE_BLANK = '1;

  // Bus word for transfer index 0..3 (EN, DIGL, DIGH, DP).
  function automatic logic [DATA_W-1:0] image_word(input disp_image_t img,
                                                   input logic [1:0] idx);
    case (idx)
      2'd0:    return {24'h0, img.en};
      2'd1:    return img.digits[31:0];
      2'd2:    return img.digits[63:32];
      default: return {24'h0, img.dp};
    endcase
  endfunction

endpackage

// File: rtl/mfp_ahb_disp_writer_if.sv
// AHB-Lite single-master link between the display writer and the display
// slave. master: drives address/control/write data, samples HREADY/HRESP.
// slave: the opposite direction.
interface mfp_ahb_disp_writer_if;
  import mfp_ahb_disp_writer_pkg::*;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP
  );
endinterface

// File: rtl/mfp_disp_refresh_timer.sv
// Free-running period counter for display auto-refresh.
// Ports: clk, rst (sync, active high), clear (restart count from 0),
// wrap_c (combinational, high in the last cycle of each period).
module mfp_disp_refresh_timer #(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic wrap_c
);
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign wrap_c = (cnt_q == CNT_W'(PERIOD - 1));

  // Count 0..PERIOD-1 and wrap; an accepted start realigns the period.
  always_ff @(posedge clk) begin
    if (rst || clear || wrap_c) cnt_q <= '0;
    else                        cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: rtl/mfp_ahb_disp_writer.sv
// AHB-Lite master that writes a full seven-segment image (enable, digits
// low, digits high, decimal points) to the display slave as four pipelined
// single-word NONSEQ writes.
// Ports: HCLK, HRESET (sync, active high); start + en_val/digits_val/dp_val
// request side; busy/done/err status; bus = AHB-Lite master modport.
// Optional: define MFP_DISP_WRITER_AUTO_REFRESH_EN to re-send the current
// snapshot every REFRESH_CYCLES cycles while idle.
module mfp_ahb_disp_writer
  import mfp_ahb_disp_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EN_ADDR   = DISP_EN_ADDR,
  parameter logic [ADDR_W-1:0] DIGL_ADDR = DISP_DIGL_ADDR,
  parameter logic [ADDR_W-1:0] DIGH_ADDR = DISP_DIGH_ADDR,
  parameter logic [ADDR_W-1:0] DP_ADDR   = DISP_DP_ADDR
`ifdef MFP_DISP_WRITER_AUTO_REFRESH_EN
  , parameter int unsigned     REFRESH_CYCLES = 50_000_000
`endif
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                start,
  input  logic [7:0]          en_val,
  input  logic [DIGITS_W-1:0] digits_val,
  input  logic [7:0]          dp_val,
  output logic                busy,
  output logic                done,
  output logic                err,
  mfp_ahb_disp_writer_if.master bus
);

  disp_state_e       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  disp_image_t       snap_q, snap_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              launch;
  logic              data_err_c;
  logic              refresh_wrap;

  function automatic logic [ADDR_W-1:0] reg_addr(input logic [1:0] i);
    case (i)
      2'd0:    return EN_ADDR;
      2'd1:    return DIGL_ADDR;
      2'd2:    return DIGH_ADDR;
      default: return DP_ADDR;
    endcase
  endfunction

`ifdef MFP_DISP_WRITER_AUTO_REFRESH_EN
  mfp_disp_refresh_timer #(.PERIOD(REFRESH_CYCLES)) u_refresh_timer (
    .clk   (HCLK),
    .rst   (HRESET),
    .clear (start && (state_q == S_IDLE)),
    .wrap_c(refresh_wrap)
  );
`else
  assign refresh_wrap = 1'b0;
`endif

  // First cycle of a two-cycle ERROR response while a data phase is open.
  assign data_err_c = ((state_q == S_PIPE) || (state_q == S_LAST)) &&
                      bus.HRESP && !bus.HREADY;

  // Cancel the pending address combinationally in the first error cycle.
  assign bus.HTRANS = data_err_c ? HTRANS_IDLE : htrans_q;
  assign bus.HWRITE = hwrite_q && !data_err_c;
  assign bus.HADDR  = haddr_q;
  assign bus.HWDATA = hwdata_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Next-state and bus output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    launch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d = '{en: en_val, digits: digits_val, dp: dp_val};
          err_d  = 1'b0;
          launch = 1'b1;
        end else if (refresh_wrap) begin
          launch = 1'b1;
        end
        if (launch) begin
          state_d  = S_ADDR;
          busy_d   = 1'b1;
          idx_d    = 2'd0;
          haddr_d  = reg_addr(2'd0);
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          state_d  = S_PIPE;
          idx_d    = 2'd1;
          haddr_d  = reg_addr(2'd1);
          hwdata_d = image_word(snap_q, 2'd0);
        end
      end
      S_PIPE: begin
        if (data_err_c) begin
          state_d  = S_ERR1;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
        end else if (bus.HREADY) begin
          hwdata_d = image_word(snap_q, idx_q);
          if (idx_q == 2'd3) begin
            state_d  = S_LAST;
            htrans_d = HTRANS_IDLE;
            hwrite_d = 1'b0;
          end else begin
            idx_d   = idx_q + 2'd1;
            haddr_d = reg_addr(idx_q + 2'd1);
          end
        end
      end
      S_LAST: begin
        if (data_err_c) begin
          state_d = S_ERR1;
        end else if (bus.HREADY) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_ERR1: begin
        if (bus.HRESP && bus.HREADY) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      snap_q   <= IMAGE_BLANK;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_disp_writer.sv
// Directed self-checking bench for mfp_ahb_disp_writer. Cycle 0 is the
// cycle in which start is presented; outputs are sampled on the falling edge.
module tb_mfp_ahb_disp_writer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [7:0]  en_val;
  logic [63:0] digits_val;
  logic [7:0]  dp_val;
  logic        busy;
  logic        done;
  logic        err;

  mfp_ahb_disp_writer_if bus();

`ifdef MFP_DISP_WRITER_AUTO_REFRESH_EN
  mfp_ahb_disp_writer #(.REFRESH_CYCLES(20)) dut (
`else
  mfp_ahb_disp_writer dut (
`endif
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .en_val    (en_val),
    .digits_val(digits_val),
    .dp_val    (dp_val),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers;
  int dones;
  int dp_issues;

  logic [31:0] exp_addr [4] = '{32'h1F70_0000, 32'h1F70_0004, 32'h1F70_0008, 32'h1F70_000C};
  logic [31:0] exp_a    [4] = '{32'h0000_00F0, 32'h0506_0708, 32'h0102_0304, 32'h0000_00FE};
  logic [31:0] exp_b    [4] = '{32'h0000_000F, 32'h3333_4444, 32'h1111_2222, 32'h0000_007F};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Sample point of the current cycle; also tallies bus activity.
  task automatic observe();
    @(negedge HCLK);
    if (bus.HTRANS == 2'b10 && bus.HREADY) xfers++;
    if (bus.HTRANS == 2'b10 && bus.HADDR == 32'h1F70_000C) dp_issues++;
    if (done) dones++;
  endtask

  task automatic set_a();
    en_val = 8'hF0; digits_val = 64'h0102_0304_0506_0708; dp_val = 8'hFE;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; start = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    tick(); tick();
    HRESET = 1'b0;
    xfers = 0; dones = 0; dp_issues = 0;
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    set_a();
    xfers = 0; dones = 0; dp_issues = 0;

    // Reset values
    tick();
    observe();
    check_eq("rst htrans", 64'(bus.HTRANS), 64'h0);
    check_eq("rst haddr",  64'(bus.HADDR),  64'h0);
    check_eq("rst hwrite", 64'(bus.HWRITE), 64'h0);
    check_eq("rst hwdata", 64'(bus.HWDATA), 64'h0);
    check_eq("rst hsize",  64'(bus.HSIZE),  64'h2);
    check_eq("rst hburst", 64'(bus.HBURST), 64'h0);
    check_eq("rst status", {61'h0, busy, done, err}, 64'h0);

    // Test 1: zero-wait write
    do_reset();
    set_a();
    start = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      observe();
      if (c >= 1 && c <= 4) begin
        check_eq($sformatf("t1 haddr c%0d", c), 64'(bus.HADDR), 64'(exp_addr[c-1]));
        check_eq($sformatf("t1 htrans c%0d", c), 64'(bus.HTRANS), 64'h2);
        check_eq($sformatf("t1 hwrite c%0d", c), 64'(bus.HWRITE), 64'h1);
      end
      if (c >= 2 && c <= 5)
        check_eq($sformatf("t1 hwdata c%0d", c), 64'(bus.HWDATA), 64'(exp_a[c-2]));
      if (c == 5) check_eq("t1 htrans last", 64'(bus.HTRANS), 64'h0);
      check_eq($sformatf("t1 done c%0d", c), 64'(done), 64'(c == 6));
      check_eq($sformatf("t1 busy c%0d", c), 64'(busy), 64'(c >= 1 && c <= 5));
      tick();
      start = 1'b0;
    end
    check_eq("t1 xfers", 64'(xfers), 64'd4);
    check_eq("t1 dones", 64'(dones), 64'd1);

    // Test 2: two wait states in the DIGL data phase
    do_reset();
    start = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      bus.HREADY = !(c == 3 || c == 4);
      observe();
      if (c >= 3 && c <= 5) begin
        check_eq($sformatf("t2 haddr hold c%0d", c), 64'(bus.HADDR), 64'h1F70_0008);
        check_eq($sformatf("t2 hwdata hold c%0d", c), 64'(bus.HWDATA), 64'h0506_0708);
        check_eq($sformatf("t2 htrans hold c%0d", c), 64'(bus.HTRANS), 64'h2);
      end
      if (c == 6) begin
        check_eq("t2 haddr c6", 64'(bus.HADDR), 64'h1F70_000C);
        check_eq("t2 hwdata c6", 64'(bus.HWDATA), 64'h0102_0304);
      end
      if (c == 7) check_eq("t2 hwdata c7", 64'(bus.HWDATA), 64'hFE);
      check_eq($sformatf("t2 done c%0d", c), 64'(done), 64'(c == 8));
      tick();
      start = 1'b0;
    end
    bus.HREADY = 1'b1;
    check_eq("t2 xfers", 64'(xfers), 64'd4);

    // Test 3: ERROR response on the DIGH data phase
    do_reset();
    start = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      bus.HRESP  = (c == 4 || c == 5);
      bus.HREADY = (c != 4);
      observe();
      if (c == 4) begin
        check_eq("t3 htrans cancel", 64'(bus.HTRANS), 64'h0);
        check_eq("t3 hwrite cancel", 64'(bus.HWRITE), 64'h0);
      end
      if (c == 5) check_eq("t3 htrans err2", 64'(bus.HTRANS), 64'h0);
      if (c == 6) begin
        check_eq("t3 err", 64'(err), 64'h1);
        check_eq("t3 busy", 64'(busy), 64'h0);
      end
      tick();
      start = 1'b0;
    end
    bus.HRESP = 1'b0; bus.HREADY = 1'b1;
    check_eq("t3 dp issued", 64'(dp_issues), 64'd0);
    check_eq("t3 dones", 64'(dones), 64'd0);
    start = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      observe();
      if (c == 0) check_eq("t3 err before restart", 64'(err), 64'h1);
      if (c == 1) check_eq("t3 err cleared", 64'(err), 64'h0);
      if (c == 6) check_eq("t3 restart done", 64'(done), 64'h1);
      tick();
      start = 1'b0;
    end

    // Test 4: start while busy is dropped
    do_reset();
    start = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 3) begin
        start = 1'b1; en_val = 8'h00; digits_val = 64'h0; dp_val = 8'h00;
      end
      observe();
      if (c == 5) check_eq("t4 hwdata dp", 64'(bus.HWDATA), 64'hFE);
      tick();
      start = 1'b0;
    end
    set_a();
    check_eq("t4 xfers", 64'(xfers), 64'd4);
    check_eq("t4 dones", 64'(dones), 64'd1);
    check_eq("t4 busy end", 64'(busy), 64'h0);

    // Test 5: reset in the middle of a sequence
    do_reset();
    start = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      HRESET = (c == 3);
      observe();
      if (c == 4) begin
        check_eq("t5 htrans", 64'(bus.HTRANS), 64'h0);
        check_eq("t5 busy",   64'(busy),       64'h0);
        check_eq("t5 haddr",  64'(bus.HADDR),  64'h0);
        check_eq("t5 hwdata", 64'(bus.HWDATA), 64'h0);
        check_eq("t5 hwrite", 64'(bus.HWRITE), 64'h0);
      end
      tick();
      start = 1'b0;
    end
    HRESET = 1'b0;
    check_eq("t5 dones", 64'(dones), 64'd0);

    // Reset and start in the same cycle: reset wins
    do_reset();
    HRESET = 1'b1; start = 1'b1;
    tick();
    HRESET = 1'b0; start = 1'b0;
    observe();
    check_eq("rs busy", 64'(busy), 64'h0);
    check_eq("rs htrans", 64'(bus.HTRANS), 64'h0);
    tick();
    observe();
    check_eq("rs busy later", 64'(busy), 64'h0);
    check_eq("rs xfers", 64'(xfers), 64'd0);

`ifdef MFP_DISP_WRITER_AUTO_REFRESH_EN
    // Test 6: auto-refresh every 20 cycles; start on a wrap relatches
    do_reset();
    set_a();
    start = 1'b1;
    for (int c = 0; c <= 46; c++) begin
      if (c == 40) begin
        start = 1'b1; en_val = 8'h0F; digits_val = 64'h1111_2222_3333_4444; dp_val = 8'h7F;
      end
      observe();
      if (c == 15) check_eq("t6 idle between", 64'(busy), 64'h0);
      if (c >= 21 && c <= 24) begin
        check_eq($sformatf("t6 haddr c%0d", c), 64'(bus.HADDR), 64'(exp_addr[c-21]));
        check_eq($sformatf("t6 htrans c%0d", c), 64'(bus.HTRANS), 64'h2);
      end
      if (c >= 22 && c <= 25)
        check_eq($sformatf("t6 hwdata c%0d", c), 64'(bus.HWDATA), 64'(exp_a[c-22]));
      if (c == 26) check_eq("t6 done", 64'(done), 64'h1);
      if (c >= 42 && c <= 45)
        check_eq($sformatf("t6 new hwdata c%0d", c), 64'(bus.HWDATA), 64'(exp_b[c-42]));
      tick();
      start = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
